// File: rtl/dual_port_ram_if.sv
// rtl/dual_port_ram_if.sv - signal bundle for one access port of dual_port_ram
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  en;
  logic [NB-1:0]         we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;

  modport master (output en, we, addr, din, input dout, dout_valid);
  modport slave  (input en, we, addr, din, output dout, dout_valid);
endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - true dual-port RAM with byte-lane writes and 1/2-cycle read latency
module dual_port_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input logic            clk,
  input logic            rst_n,
  dual_port_ram_if.slave a,
  dual_port_ram_if.slave b
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                 p_en;
  logic [1:0][NB-1:0]         p_we;
  logic [1:0][ADDR_WIDTH-1:0] p_addr;
  logic [1:0][DATA_WIDTH-1:0] p_din;
  logic [1:0][DATA_WIDTH-1:0] p_dout;
  logic [1:0]                 p_valid;

  assign p_en   = {b.en, a.en};
  assign p_we   = {b.we, a.we};
  assign p_addr = {b.addr, a.addr};
  assign p_din  = {b.din, a.din};

  assign a.dout       = p_dout[0];
  assign a.dout_valid = p_valid[0];
  assign b.dout       = p_dout[1];
  assign b.dout_valid = p_valid[1];

  // Array write: B lanes first so that A overrides on lanes both ports write; ignored in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (p_en[1] && p_we[1][i])
          mem[p_addr[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[1][i*BYTE_WIDTH +: BYTE_WIDTH];
        if (p_en[0] && p_we[0][i])
          mem[p_addr[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[0][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wf_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  same_addr;
    logic                  is_wr;

    assign rd_word   = mem[p_addr[p]];
    assign same_addr = p_en[O] && (p_addr[O] == p_addr[p]);
    assign is_wr     = |p_we[p];

    // Word as it will read after this edge's writes land, port A taking shared lanes.
    always_comb begin
      wf_word = rd_word;
      for (int i = 0; i < NB; i++) begin
        if (p_we[p][i] && (p == 0 || !(same_addr && p_we[O][i])))
          wf_word[i*BYTE_WIDTH +: BYTE_WIDTH] = p_din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        else if (same_addr && p_we[O][i])
          wf_word[i*BYTE_WIDTH +: BYTE_WIDTH] = p_din[O][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    // First read stage: capture according to access type and write mode, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= 1'b0;
        if (p_en[p]) begin
          if (!is_wr || WRITE_MODE == 0) begin
            s1_data  <= rd_word;
            s1_valid <= 1'b1;
          end else if (WRITE_MODE == 1) begin
            s1_data  <= wf_word;
            s1_valid <= 1'b1;
          end
        end
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      // Second stage: forwards every valid word so back-to-back accesses stream out in order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid)
            s2_data <= s1_data;
        end
      end

      assign p_dout[p]  = s2_data;
      assign p_valid[p] = s2_valid;
    end else begin : g_lat1
      assign p_dout[p]  = s1_data;
      assign p_valid[p] = s1_valid;
    end
  end
endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - self-checking bench for dual_port_ram across write modes and latencies
module tb_dual_port_ram;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 4;
  localparam int NB = DW / BW;
  localparam int NK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [NB-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic [DW-1:0] o_d [NK][2];
  logic          o_v [NK][2];

  // Instances: k0 mode0/lat1, k1 mode1/lat1, k2 mode2/lat1, k3 mode0/lat2
  for (genvar g = 0; g < NK; g++) begin : g_dut
    dual_port_ram_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) ia ();
    dual_port_ram_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) ib ();
    assign ia.en = a_en;  assign ia.we = a_we;  assign ia.addr = a_addr;  assign ia.din = a_din;
    assign ib.en = b_en;  assign ib.we = b_we;  assign ib.addr = b_addr;  assign ib.din = b_din;
    assign o_d[g][0] = ia.dout;  assign o_v[g][0] = ia.dout_valid;
    assign o_d[g][1] = ib.dout;  assign o_v[g][1] = ib.dout_valid;
    dual_port_ram #(
      .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
      .READ_LATENCY(g == 3 ? 2 : 1), .WRITE_MODE(g == 3 ? 0 : g)
    ) u_dut (.clk(clk), .rst_n(rst_n), .a(ia), .b(ib));
  end

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] rec_d [4][NK][2];
  logic          rec_v [4][NK][2];
  logic [DW-1:0] exp_d [NK][2];
  int cyc = 0;
  int flush = 0;
  int passed = 0;
  int total = 0;

  function automatic int mode_of(int k);
    return (k == 3) ? 0 : k;
  endfunction

  function automatic int lat_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(logic ae, logic [NB-1:0] aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
                       logic be, logic [NB-1:0] bw, logic [AW-1:0] ba, logic [DW-1:0] bd);
    a_en = ae; a_we = aw; a_addr = aa; a_din = ad;
    b_en = be; b_we = bw; b_addr = ba; b_din = bd;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic model_reset();
    flush = cyc;
    for (int k = 0; k < NK; k++)
      for (int p = 0; p < 2; p++) exp_d[k][p] = '0;
  endtask

  // Reference: memory before/after this edge, then what each instance should emit for it.
  task automatic model_access();
    logic [DW-1:0] pre [16];
    logic          pen [2];
    logic [NB-1:0] pwe [2];
    logic [AW-1:0] pad [2];
    logic [DW-1:0] pdi [2];
    logic          v;
    logic [DW-1:0] d;
    int slot;
    pen[0] = a_en; pwe[0] = a_we; pad[0] = a_addr; pdi[0] = a_din;
    pen[1] = b_en; pwe[1] = b_we; pad[1] = b_addr; pdi[1] = b_din;
    for (int i = 0; i < 16; i++) pre[i] = ref_mem[i];
    if (rst_n) begin
      for (int p = 1; p >= 0; p--)
        if (pen[p])
          for (int l = 0; l < NB; l++)
            if (pwe[p][l]) ref_mem[pad[p]][l*BW +: BW] = pdi[p][l*BW +: BW];
    end
    slot = cyc % 4;
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < 2; p++) begin
        v = 1'b0;
        d = '0;
        if (rst_n && pen[p]) begin
          case (mode_of(k))
            0: begin v = 1'b1; d = pre[pad[p]]; end
            1: begin v = 1'b1; d = (pwe[p] != 0) ? ref_mem[pad[p]] : pre[pad[p]]; end
            default: begin v = (pwe[p] == 0); d = pre[pad[p]]; end
          endcase
        end
        rec_v[slot][k][p] = v;
        rec_d[slot][k][p] = d;
      end
    end
  endtask

  task automatic check_outputs();
    int idx;
    logic v;
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < 2; p++) begin
        idx = cyc - (lat_of(k) - 1);
        v = 1'b0;
        if (idx >= flush && idx >= 0) v = rec_v[idx % 4][k][p];
        if (v) exp_d[k][p] = rec_d[idx % 4][k][p];
        check($sformatf("c%0d_k%0d_p%0d_dout", cyc, k, p), o_d[k][p], exp_d[k][p]);
        check($sformatf("c%0d_k%0d_p%0d_valid", cyc, k, p), DW'(o_v[k][p]), DW'(v));
      end
    end
  endtask

  task automatic step();
    model_access();
    @(posedge clk);
    #1;
    check_outputs();
    cyc = cyc + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NK; k++)
      for (int p = 0; p < 2; p++) exp_d[k][p] = '0;
    idle();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NK; k++)
      for (int p = 0; p < 2; p++) begin
        check($sformatf("reset_k%0d_p%0d_dout", k, p), o_d[k][p], '0);
        check($sformatf("reset_k%0d_p%0d_valid", k, p), DW'(o_v[k][p]), '0);
      end
    #10 rst_n = 1'b1;

    // Fill memory with known random content
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'hF, AW'(i), $urandom, 1'b0, '0, '0, '0);
      step();
    end

    // Basic write then read
    drive(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, '0); step();
    drive(1'b1, 4'h0, 4'd3, '0, 1'b0, '0, '0, '0); step();
    check("basic_rd_dout", o_d[0][0], 32'hDEADBEEF);
    check("basic_rd_valid", DW'(o_v[0][0]), 32'd1);

    // Byte lanes
    drive(1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, '0, '0, '0); step();
    drive(1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0, '0, '0, '0); step();
    drive(1'b1, 4'h0, 4'd5, '0, 1'b0, '0, '0, '0); step();
    check("lanes_dout", o_d[0][0], 32'h11BB33DD);

    // Same-port write modes
    drive(1'b1, 4'hF, 4'd2, 32'h0, 1'b0, '0, '0, '0); step();
    drive(1'b1, 4'h0, 4'd5, '0, 1'b0, '0, '0, '0); step();
    drive(1'b1, 4'hF, 4'd2, 32'h5A5A5A5A, 1'b0, '0, '0, '0); step();
    check("mode0_dout", o_d[0][0], 32'h0);
    check("mode0_valid", DW'(o_v[0][0]), 32'd1);
    check("mode1_dout", o_d[1][0], 32'h5A5A5A5A);
    check("mode1_valid", DW'(o_v[1][0]), 32'd1);
    check("mode2_dout", o_d[2][0], 32'h11BB33DD);
    check("mode2_valid", DW'(o_v[2][0]), 32'd0);

    // Cross-port collisions
    drive(1'b1, 4'b0001, 4'd7, 32'h000000AA, 1'b1, 4'hF, 4'd7, 32'hBBBBBBBB); step();
    drive(1'b1, 4'h0, 4'd7, '0, 1'b0, '0, '0, '0); step();
    check("ww_collision_dout", o_d[0][0], 32'hBBBBBBAA);
    drive(1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1, 4'h0, 4'd7, '0); step();
    for (int k = 0; k < 3; k++)
      check($sformatf("rw_collision_k%0d_bdout", k), o_d[k][1], 32'hBBBBBBAA);

    // Back-to-back reads on the two-stage instance
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, AW'(i), '0, 1'b0, '0, '0, '0);
      step();
    end
    idle(); step();
    check("lat2_last_dout", o_d[3][0], 32'hDEADBEEF);
    check("lat2_last_valid", DW'(o_v[3][0]), 32'd1);
    step();
    check("lat2_after_valid", DW'(o_v[3][0]), 32'd0);

    // Reset with a read in flight; writes during reset are dropped
    drive(1'b1, 4'h0, 4'd3, '0, 1'b0, '0, '0, '0); step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_k3_dout", o_d[3][0], '0);
    check("midrst_k3_valid", DW'(o_v[3][0]), 32'd0);
    check("midrst_k0_dout", o_d[0][0], '0);
    drive(1'b1, 4'hF, 4'd3, 32'hFFFFFFFF, 1'b1, 4'hF, 4'd4, 32'hFFFFFFFF);
    step();
    step();
    idle();
    rst_n = 1'b1;
    step();
    check("postrst_k3_valid", DW'(o_v[3][0]), 32'd0);
    drive(1'b1, 4'h0, 4'd3, '0, 1'b0, '0, '0, '0); step();
    check("postrst_k0_dout", o_d[0][0], 32'hDEADBEEF);
    idle(); step();
    check("postrst_k3_dout", o_d[3][0], 32'hDEADBEEF);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (n == 203) rst_n = 1'b1;
      a_en   = ($urandom_range(0, 3) != 0);
      a_we   = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
      a_addr = AW'($urandom_range(0, 15));
      a_din  = $urandom;
      b_en   = ($urandom_range(0, 3) != 0);
      b_we   = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
      b_addr = ($urandom_range(0, 1) == 1) ? a_addr : AW'($urandom_range(0, 15));
      b_din  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
